ps2_kbd_rx: RTL and testbench
=============================

// Module: ps2_kbd_rx
// PURPOSE
//  System-clocked PS/2 keyboard receiver. Synchronises and filters the PS/2 clock/data lines,
//  frames 11-bit packets, and checks start, odd parity and stop. It folds E0/F0 prefixes into
//  make/break events and buffers them in a FIFO with a valid/ready pop interface.
//  Sits between the keyboard pins and the game-control logic; supersedes raw shift-register capture.
// PARAMETERS
//  SYNC_STAGES     2       flops per input synchroniser (>=2)
//  FILTER_LEN      4       consecutive equal kclk samples needed to change filtered kclk (>=1)
//  TIMEOUT_CYCLES  100000  clk cycles without a kclk fall mid-frame before abort (2 ms @ 50 MHz)
//  FIFO_DEPTH      8       event FIFO entries; power of two, >=2
// PORTS
//  clk        in   1  system clock
//  rst_n      in   1  asynchronous active-low reset
//  kclk       in   1  PS/2 clock pin (async)
//  data       in   1  PS/2 data pin (async)
//  evt_valid  out  1  FIFO non-empty
//  evt_ready  in   1  consumer pops head when evt_valid & evt_ready
//  evt_code   out  8  head scan code (without prefixes)
//  evt_ext    out  1  head event was E0-prefixed
//  evt_brk    out  1  head event was F0-prefixed (key release)
//  last_code  out  8  most recent accepted non-prefix code
//  frame_err  out  1  one-cycle pulse per bad or aborted frame
//  err_led    out  1  high from a frame error until the next good frame
//  overflow   out  1  sticky; set when a push hits a full FIFO
//  ovf_clr    in   1  clears overflow (a same-cycle set wins)
//  busy       out  1  receive FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0. Synchroniser and filter flops reset to 1 (bus idle). FIFO empty, prefix flags clear.
//  Filter: kclk_f toggles only after FILTER_LEN consecutive synced samples differ from it.
//   fall = 1-cycle strobe on kclk_f 1->0. data_s is sampled on fall.
//  FSM IDLE: fall & data_s==0 -> RECV with bit_cnt=0. fall & data_s==1 -> ignored, stay IDLE.
//  FSM RECV: each fall shifts data LSB-first. bit_cnt 0..7 = data, 8 = parity, 9 = stop.
//   The fall with bit_cnt==9 -> CHECK.
//  FSM CHECK (1 cycle): good = (^{byte,parity})==1 && stop==1. Always -> IDLE.
//   bad: frame_err pulse, err_led=1, clear ext/brk flags, nothing pushed.
//  Timeout: watchdog counts in RECV and resets on each fall.
//   Reaching TIMEOUT_CYCLES-1 -> IDLE, frame_err pulse, err_led=1, partial bits discarded, flags cleared.
//  Decode (good frame): err_led=0.
//   E0 -> ext_f=1. F0 -> brk_f=1.
//   Any other byte (incl. E1, AA, FA, FE) -> push {ext_f,brk_f,byte}, last_code<=byte, clear both flags.
//  Latency: stop bit sampled in cycle N. CHECK in N+1. FIFO write at end of N+1. evt_valid=1 in N+2 (empty FIFO).
//  FIFO: first-word-fall-through. Outputs show head combinationally from registered storage. Pointers wrap mod FIFO_DEPTH.
//   Full & push & !pop -> event dropped, overflow=1, flags still cleared.
//   Full & push & pop -> both accepted, count unchanged.
//   Empty & pop -> ignored. Empty & push & pop -> push only.
//  Reset asserted mid-frame: immediate return to IDLE, FIFO flushed.
//   After release, the first frame is accepted only from a fresh start bit.
// STRUCTURE
//  Package ps2_pkg: constants PS2_EXT=8'hE0, PS2_BRK=8'hF0. FSM enum {IDLE,RECV,CHECK}.
//   Event record type {ext,brk,code[7:0]} (10 bits).
//  Sub-module ps2_evt_fifo: parameterised sync FIFO (WIDTH=10, DEPTH=FIFO_DEPTH) with push/pop/full/empty.
//  Top holds the synchronisers, filter, edge detect, FSM, watchdog, prefix flags and status regs.
// TESTING
//  1 Frame 0x1D (start 0, bits LSB-first, parity 1, stop 1) -> evt_valid, code=1D, ext=0, brk=0, last_code=1D.
//  2 Frames F0,1D then E0,F0,75 -> two events {0,1,1D} and {1,1,75}. No events for prefix bytes.
//  3 0x1D frame with parity bit 0 -> frame_err 1-cycle pulse, err_led=1, no push. Next good frame clears err_led.
//  4 Stop after 5 data bits for >TIMEOUT_CYCLES -> busy falls, frame_err pulse. Following 0x23 frame decodes correctly.
//  5 Send FIFO_DEPTH+1 codes with evt_ready=0 -> 8 held, 9th dropped, overflow=1. ovf_clr clears it. Pops return codes in order.
//  6 1-cycle kclk glitches (< FILTER_LEN) injected mid-frame -> no extra bits captured, code intact.
//   Reset asserted at bit 4 -> outputs 0, clean next frame.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  // Prefix bytes folded into the event flags rather than reported as events.
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  localparam int PS2_EVT_W = $bits(ps2_evt_t);

  // frame[7:0] = data, frame[8] = parity, frame[9] = stop.
  // Odd parity means data plus parity must hold an odd number of ones.
  function automatic logic ps2_frame_ok(input logic [9:0] frame);
    return (^frame[8:0]) & frame[9];
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous first-word-fall-through FIFO holding decoded key events.
// Latency: a push is visible on pop_dat/!empty the cycle after the write edge.
// Backpressure: push into a full FIFO is dropped unless a pop happens in the same cycle.
// Ports: clk, rst_n (async active-low); push/push_dat write side;
//        pop/pop_dat read side (pop_dat shows the head); full, empty status.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int WIDTH = PS2_EVT_W,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign pop_dat = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot the write pointer addresses, so the push can be accepted.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync/filter pins, frame and check packets, fold E0/F0 into events.
// Latency: stop bit sampled in cycle N, CHECK in N+1, event visible on evt_valid in N+2.
// Backpressure: evt_valid/evt_ready pop; a full FIFO drops new events and sets sticky overflow.
// Ports: clk, rst_n; kclk/data async pins; evt_valid/evt_ready/evt_code/evt_ext/evt_brk event head;
//        last_code, frame_err pulse, err_led, overflow (cleared by ovf_clr), busy status.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kclk,
  input  logic       data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic [7:0] last_code,
  output logic       frame_err,
  output logic       err_led,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic       busy
);

  localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FLT_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [WDW-1:0] WD_MAX  = WDW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] kclk_sync_q, kclk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   kclk_f_q, kclk_f_d;
  logic                   kclk_f_prev_q;
  logic [FCW-1:0]         flt_cnt_q, flt_cnt_d;
  logic                   kclk_s, data_s, fall;

  ps2_state_e             state_q, state_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             frame_q, frame_d;
  logic [WDW-1:0]         wdog_q, wdog_d;
  logic                   ext_q, ext_d;
  logic                   brk_q, brk_d;
  logic [7:0]             last_code_q, last_code_d;
  logic                   frame_err_q, frame_err_d;
  logic                   err_led_q, err_led_d;
  logic                   overflow_q, overflow_d;

  logic                   push, pop, fifo_full, fifo_empty;
  ps2_evt_t               push_evt, head_evt;

  assign kclk_s = kclk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = kclk_f_prev_q & ~kclk_f_q;

  // Synchronisers and kclk glitch filter. The filtered clock only moves after
  // FILTER_LEN consecutive samples disagree with it; any agreeing sample restarts the run.
  always_comb begin
    kclk_sync_d = {kclk_sync_q[SYNC_STAGES-2:0], kclk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data};
    kclk_f_d    = kclk_f_q;
    flt_cnt_d   = '0;
    if (kclk_s != kclk_f_q) begin
      if (flt_cnt_q == FLT_MAX) begin
        kclk_f_d = kclk_s;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  // Receive FSM, watchdog and decode.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_d     = frame_q;
    wdog_d      = wdog_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    last_code_d = last_code_q;
    err_led_d   = err_led_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (fall && !data_s) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end
      end
      RECV: begin
        if (fall) begin
          // LSB-first: after ten shifts frame_q holds {stop, parity, data[7:0]}.
          frame_d = {data_s, frame_q[9:1]};
          wdog_d  = '0;
          if (bit_cnt_q == 4'd9) begin
            state_d = CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (wdog_q == WD_MAX) begin
          state_d     = IDLE;
          wdog_d      = '0;
          frame_err_d = 1'b1;
          err_led_d   = 1'b1;
          ext_d       = 1'b0;
          brk_d       = 1'b0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (ps2_frame_ok(frame_q)) begin
          err_led_d = 1'b0;
          if (frame_q[7:0] == PS2_EXT) begin
            ext_d = 1'b1;
          end else if (frame_q[7:0] == PS2_BRK) begin
            brk_d = 1'b1;
          end else begin
            push        = 1'b1;
            last_code_d = frame_q[7:0];
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end else begin
          frame_err_d = 1'b1;
          err_led_d   = 1'b1;
          ext_d       = 1'b0;
          brk_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_evt = '{ext: ext_q, brk: brk_q, code: frame_q[7:0]};
  assign pop      = evt_ready & ~fifo_empty;

  // A set in the same cycle as ovf_clr wins so no drop goes unreported.
  assign overflow_d = (overflow_q & ~ovf_clr) | (push & fifo_full & ~pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kclk_sync_q   <= '1;
      data_sync_q   <= '1;
      kclk_f_q      <= 1'b1;
      kclk_f_prev_q <= 1'b1;
      flt_cnt_q     <= '0;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      frame_q       <= '0;
      wdog_q        <= '0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      last_code_q   <= '0;
      frame_err_q   <= 1'b0;
      err_led_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      kclk_sync_q   <= kclk_sync_d;
      data_sync_q   <= data_sync_d;
      kclk_f_q      <= kclk_f_d;
      kclk_f_prev_q <= kclk_f_q;
      flt_cnt_q     <= flt_cnt_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_q       <= frame_d;
      wdog_q        <= wdog_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      last_code_q   <= last_code_d;
      frame_err_q   <= frame_err_d;
      err_led_q     <= err_led_d;
      overflow_q    <= overflow_d;
    end
  end

  ps2_evt_fifo #(
    .WIDTH (PS2_EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (push_evt),
    .pop      (pop),
    .pop_dat  (head_evt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign evt_code  = head_evt.code;
  assign evt_ext   = head_evt.ext;
  assign evt_brk   = head_evt.brk;
  assign last_code = last_code_q;
  assign frame_err = frame_err_q;
  assign err_led   = err_led_q;
  assign overflow  = overflow_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_kbd_rx.sv
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

  localparam int TO    = 400;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kclk = 1'b1;
  logic       data = 1'b1;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid, evt_ext, evt_brk, frame_err, err_led, overflow, busy;
  logic [7:0] evt_code, last_code;

  int n_checks = 0;
  int n_pass   = 0;
  int ferr_rise = 0;
  int ferr_hi   = 0;
  logic ferr_prev = 1'b0;
  logic [9:0] exp_q[$];

  ps2_kbd_rx #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kclk      (kclk),
    .data      (data),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_brk   (evt_brk),
    .last_code (last_code),
    .frame_err (frame_err),
    .err_led   (err_led),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count frame_err pulses and total high cycles, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_err) ferr_hi++;
    if (frame_err && !ferr_prev) ferr_rise++;
    ferr_prev = frame_err;
  end

  // One PS/2 bit: 10 cycles high, 20 low (fall at c=10), 10 high. Optional 1-cycle glitches.
  task automatic send_bit(input logic v, input bit glitch);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) data = v;
      kclk = (c >= 10 && c < 30) ? 1'b0 : 1'b1;
      if (glitch && (c == 3 || c == 20)) kclk = ~kclk;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i], glitch);
    data = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Start bit followed by the first nbits data bits, then the bus is left idle.
  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i], 1'b0);
    data = 1'b1;
  endtask

  // Wait (bounded) for an event, capture the head and pop it.
  task automatic pop_one(output logic [9:0] got, output bit ok);
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (evt_valid) begin
        got = {evt_ext, evt_brk, evt_code};
        ok  = 1'b1;
        break;
      end
    end
    if (ok) begin
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({evt_valid, evt_ext, evt_brk, evt_code} !== 11'h0)
      $display("FAIL reset_evt got=%h want=0", {evt_valid, evt_ext, evt_brk, evt_code});
    else n_pass++;
    n_checks++;
    if ({last_code, frame_err, err_led} !== 10'h0)
      $display("FAIL reset_status got=%h want=0", {last_code, frame_err, err_led});
    else n_pass++;
    n_checks++;
    if ({overflow, busy} !== 2'b00)
      $display("FAIL reset_ovf_busy got=%b want=00", {overflow, busy});
    else n_pass++;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single;
    logic [9:0] got, exp;
    bit ok;
    send_frame(8'h1D, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 8'h1D});
    pop_one(got, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) $display("FAIL single_evt got=%h ok=%0d want=%h", got, ok, exp);
    else n_pass++;
    n_checks++;
    if (last_code !== 8'h1D) $display("FAIL single_last got=%h want=1d", last_code);
    else n_pass++;
  endtask

  task automatic test_prefix;
    logic [9:0] got, exp;
    bit ok;
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1D, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b1, 8'h1D});
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    exp_q.push_back({1'b1, 1'b1, 8'h75});
    for (int k = 0; k < 2; k++) begin
      pop_one(got, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || got !== exp) $display("FAIL prefix_evt%0d got=%h ok=%0d want=%h", k, got, ok, exp);
      else n_pass++;
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (evt_valid !== 1'b0) $display("FAIL prefix_extra got=%b want=0", evt_valid);
    else n_pass++;
  endtask

  task automatic test_parity_err;
    logic [9:0] got, exp;
    bit ok;
    int r0, h0;
    r0 = ferr_rise;
    h0 = ferr_hi;
    send_frame(8'h1D, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (ferr_rise - r0 != 1 || ferr_hi - h0 != 1)
      $display("FAIL parity_pulse got=%0d/%0d want=1/1", ferr_rise - r0, ferr_hi - h0);
    else n_pass++;
    n_checks++;
    if (err_led !== 1'b1) $display("FAIL parity_led got=%b want=1", err_led);
    else n_pass++;
    n_checks++;
    if (evt_valid !== 1'b0) $display("FAIL parity_nopush got=%b want=0", evt_valid);
    else n_pass++;
    send_frame(8'h2A, 1'b0, 1'b0);
    exp_q.push_back({2'b00, 8'h2A});
    n_checks++;
    if (err_led !== 1'b0) $display("FAIL parity_ledclr got=%b want=0", err_led);
    else n_pass++;
    pop_one(got, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) $display("FAIL parity_next got=%h ok=%0d want=%h", got, ok, exp);
    else n_pass++;
  endtask

  task automatic test_timeout;
    logic [9:0] got, exp;
    bit ok;
    int r0, h0;
    r0 = ferr_rise;
    h0 = ferr_hi;
    send_partial(8'h6C, 5);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL timeout_busy got=%b want=1", busy);
    else n_pass++;
    repeat (TO + 100) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL timeout_idle got=%b want=0", busy);
    else n_pass++;
    n_checks++;
    if (ferr_rise - r0 != 1 || ferr_hi - h0 != 1)
      $display("FAIL timeout_pulse got=%0d/%0d want=1/1", ferr_rise - r0, ferr_hi - h0);
    else n_pass++;
    n_checks++;
    if ({evt_valid, err_led} !== 2'b01) $display("FAIL timeout_state got=%b want=01", {evt_valid, err_led});
    else n_pass++;
    send_frame(8'h23, 1'b0, 1'b0);
    exp_q.push_back({2'b00, 8'h23});
    pop_one(got, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) $display("FAIL timeout_next got=%h ok=%0d want=%h", got, ok, exp);
    else n_pass++;
  endtask

  task automatic test_overflow;
    logic [9:0] got, exp;
    bit ok;
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'h10 + 8'(i), 1'b0, 1'b0);
      exp_q.push_back({2'b00, 8'h10 + 8'(i)});
    end
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_early got=%b want=0", overflow);
    else n_pass++;
    send_frame(8'h3C, 1'b0, 1'b0);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_set got=%b want=1", overflow);
    else n_pass++;
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_clr got=%b want=0", overflow);
    else n_pass++;
    for (int k = 0; k < DEPTH; k++) begin
      pop_one(got, ok);
      exp = exp_q.pop_front();
      n_checks++;
      if (!ok || got !== exp) $display("FAIL ovf_pop%0d got=%h ok=%0d want=%h", k, got, ok, exp);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if (evt_valid !== 1'b0) $display("FAIL ovf_drop got=%b want=0", evt_valid);
    else n_pass++;
  endtask

  task automatic test_glitch;
    logic [9:0] got, exp;
    bit ok;
    send_frame(8'h5A, 1'b0, 1'b1);
    exp_q.push_back({2'b00, 8'h5A});
    pop_one(got, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) $display("FAIL glitch_evt got=%h ok=%0d want=%h", got, ok, exp);
    else n_pass++;
  endtask

  task automatic test_reset_midframe;
    logic [9:0] got, exp;
    bit ok;
    int r0;
    send_frame(8'h33, 1'b0, 1'b0);
    n_checks++;
    if ({evt_valid, last_code} !== {1'b1, 8'h33}) $display("FAIL rst_pre got=%h want=133", {evt_valid, last_code});
    else n_pass++;
    send_partial(8'h55, 4);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL rst_busy got=%b want=1", busy);
    else n_pass++;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({evt_valid, busy, err_led, overflow, frame_err, last_code} !== 13'h0)
      $display("FAIL rst_mid got=%h want=0", {evt_valid, busy, err_led, overflow, frame_err, last_code});
    else n_pass++;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    r0 = ferr_rise;
    send_frame(8'h4B, 1'b0, 1'b0);
    exp_q.push_back({2'b00, 8'h4B});
    pop_one(got, ok);
    exp = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== exp) $display("FAIL rst_next got=%h ok=%0d want=%h", got, ok, exp);
    else n_pass++;
    n_checks++;
    if (ferr_rise != r0) $display("FAIL rst_noerr got=%0d want=%0d", ferr_rise, r0);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_prefix;
    test_parity_err;
    test_timeout;
    test_overflow;
    test_glitch;
    test_reset_midframe;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
